// File: rtl/tof_sched_pkg.sv
// Shared state encoding and constants for the TOF configuration update scheduler.
package tof_sched_pkg;

    localparam int DIRTY_BIT         = 15;
    localparam int ADDR_BITS_DEFAULT = 7;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD,
        S_RDW,
        S_ISSUE,
        S_VRD,
        S_VRW,
        S_WR,
        S_NEXT,
        S_DONE
    } state_e;

endpackage

// File: rtl/tof_sched_bram_port.sv
// Grant-based BRAM access port: holds a request until granted and flags the
// cycle in which read data is valid on the unregistered read port.
module tof_sched_bram_port #(
    parameter int ADDR_BITS = 7
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 req_wr_i,
    input  logic [ADDR_BITS-1:0] req_addr_i,
    input  logic [15:0]          req_dat_i,
    output logic                 gnt_o,
    output logic                 rd_vld_o,
    output logic [15:0]          rd_dat_o,
    output logic                 bram_en_o,
    output logic                 bram_wr_o,
    output logic [ADDR_BITS-1:0] bram_addr_o,
    output logic [15:0]          bram_dat_o,
    input  logic                 bram_gnt_i,
    input  logic [15:0]          bram_dat_i
);

    logic                 en_q, en_d;
    logic                 wr_q, wr_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [15:0]          dat_q, dat_d;
    logic                 rd_vld_q, rd_vld_d;

    always_comb begin
        en_d     = en_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        dat_d    = dat_q;
        rd_vld_d = en_q && bram_gnt_i && !wr_q;
        if (req_i) begin
            en_d   = 1'b1;
            wr_d   = req_wr_i;
            addr_d = req_addr_i;
            dat_d  = req_dat_i;
        end else if (en_q && bram_gnt_i) begin
            en_d = 1'b0;
            wr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            dat_q    <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            en_q     <= en_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            dat_q    <= dat_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    assign gnt_o       = en_q && bram_gnt_i;
    assign rd_vld_o    = rd_vld_q;
    assign rd_dat_o    = bram_dat_i;
    assign bram_en_o   = en_q;
    assign bram_wr_o   = wr_q;
    assign bram_addr_o = addr_q;
    assign bram_dat_o  = dat_q;

endmodule

// File: rtl/tof_config_update_scheduler.sv
// Walks the config region, issues dirty words to the I2C engine and clears the
// dirty bit by read-compare-write. Optional feature: TOF_SCHED_FORCE_ALL_EN.
module tof_config_update_scheduler
    import tof_sched_pkg::*;
#(
    parameter int ADDR_BITS  = ADDR_BITS_DEFAULT,
    parameter int FIRST_ADDR = 0,
    parameter int LAST_ADDR  = 127
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 update_i,
    output logic                 updating_o,
    output logic                 done_o,
    output logic [ADDR_BITS:0]   count_o,
    output logic                 bram_en_o,
    output logic                 bram_wr_o,
    output logic [ADDR_BITS-1:0] bram_addr_o,
    output logic [15:0]          bram_dat_o,
    input  logic                 bram_gnt_i,
    input  logic [15:0]          bram_dat_i,
    output logic                 cmd_valid_o,
    input  logic                 cmd_ready_i,
    output logic [ADDR_BITS-1:0] cmd_addr_o,
    output logic [14:0]          cmd_dat_o
`ifdef TOF_SCHED_FORCE_ALL_EN
    ,
    input  logic                 force_all_i
`endif
);

    localparam logic [ADDR_BITS-1:0] FIRST_A = ADDR_BITS'(FIRST_ADDR);
    localparam logic [ADDR_BITS-1:0] LAST_A  = ADDR_BITS'(LAST_ADDR);

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] ptr_q, ptr_d;
    logic [ADDR_BITS:0]   cnt_q, cnt_d;
    logic [ADDR_BITS:0]   count_q, count_d;
    logic [15:0]          orig_q, orig_d;
    logic                 rescan_q, rescan_d;
    logic                 updating_q, updating_d;
    logic                 done_q, done_d;
    logic                 cmd_valid_q, cmd_valid_d;
    logic                 start;
    logic                 req, req_wr;
    logic [15:0]          req_dat;
    logic                 gnt, rd_vld;
    logic [15:0]          rd_dat;
    logic                 force_q;

`ifdef TOF_SCHED_FORCE_ALL_EN
    // Latest request's force flag applies to the next scan that starts.
    logic force_d, force_req_q, force_req_d;

    always_comb begin
        force_req_d = update_i ? force_all_i : force_req_q;
        force_d     = start ? force_req_d : force_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            force_q     <= 1'b0;
            force_req_q <= 1'b0;
        end else begin
            force_q     <= force_d;
            force_req_q <= force_req_d;
        end
    end
`else
    assign force_q = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        count_d  = count_q;
        orig_d   = orig_q;
        rescan_d = rescan_q | (update_i && state_q != S_IDLE);
        start    = 1'b0;
        req      = 1'b0;
        req_wr   = 1'b0;
        req_dat  = '0;
        unique case (state_q)
            S_IDLE:  if (update_i || rescan_q) start = 1'b1;
            S_RD:    if (gnt) state_d = S_RDW;
            S_RDW: if (rd_vld) begin
                orig_d  = rd_dat;
                state_d = (rd_dat[DIRTY_BIT] || force_q) ? S_ISSUE : S_NEXT;
            end
            S_ISSUE: if (cmd_ready_i) begin
                cnt_d   = cnt_q + 1'b1;
                state_d = S_VRD;
                req     = 1'b1;
            end
            S_VRD:   if (gnt) state_d = S_VRW;
            // A mismatch means a host write raced us: keep its dirty bit, rescan.
            S_VRW: if (rd_vld) begin
                if (rd_dat != orig_q) begin
                    rescan_d = 1'b1;
                    state_d  = S_NEXT;
                end else if (orig_q[DIRTY_BIT]) begin
                    state_d = S_WR;
                    req     = 1'b1;
                    req_wr  = 1'b1;
                    req_dat = {1'b0, orig_q[DIRTY_BIT-1:0]};
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_WR:    if (gnt) state_d = S_NEXT;
            S_NEXT: begin
                if (ptr_q == LAST_A) begin
                    state_d = S_DONE;
                    count_d = cnt_q;
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = S_RD;
                    req     = 1'b1;
                end
            end
            S_DONE: begin
                if (rescan_q || update_i) start = 1'b1;
                else state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (start) begin
            ptr_d    = FIRST_A;
            cnt_d    = '0;
            rescan_d = 1'b0;
            state_d  = S_RD;
            req      = 1'b1;
        end
        updating_d  = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        cmd_valid_d = (state_d == S_ISSUE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            count_q     <= '0;
            orig_q      <= '0;
            rescan_q    <= 1'b0;
            updating_q  <= 1'b0;
            done_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            count_q     <= count_d;
            orig_q      <= orig_d;
            rescan_q    <= rescan_d;
            updating_q  <= updating_d;
            done_q      <= done_d;
            cmd_valid_q <= cmd_valid_d;
        end
    end

    tof_sched_bram_port #(.ADDR_BITS(ADDR_BITS)) u_port (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req),
        .req_wr_i    (req_wr),
        .req_addr_i  (ptr_d),
        .req_dat_i   (req_dat),
        .gnt_o       (gnt),
        .rd_vld_o    (rd_vld),
        .rd_dat_o    (rd_dat),
        .bram_en_o   (bram_en_o),
        .bram_wr_o   (bram_wr_o),
        .bram_addr_o (bram_addr_o),
        .bram_dat_o  (bram_dat_o),
        .bram_gnt_i  (bram_gnt_i),
        .bram_dat_i  (bram_dat_i)
    );

    assign updating_o  = updating_q;
    assign done_o      = done_q;
    assign count_o     = count_q;
    assign cmd_valid_o = cmd_valid_q;
    assign cmd_addr_o  = ptr_q;
    assign cmd_dat_o   = orig_q[DIRTY_BIT-1:0];

endmodule

// File: doc/tof_config_update_scheduler.md
# tof_config_update_scheduler

Sequences TOF controller configuration updates in the 200 MHz domain. On an update request it walks the configuration region of the shared confmon BRAM, which is reached through the BRAM multiplexer with grant-based access. Each word whose dirty bit (bit 15, set by every host write) is set is handed to the I2C command engine. After the engine accepts it, the scheduler clears the dirty bit with a verified read-compare-write, so host writes that race the clear are never lost.

## Interface
- `ADDR_BITS`, 7: configuration word address width.
- `FIRST_ADDR`, 0: first address scanned.
- `LAST_ADDR`, 127: last address scanned (inclusive). Must satisfy `LAST_ADDR >= FIRST_ADDR`.

Ports (one clock; reset is synchronous and active-high):
- `clk_i`  in  1  200 MHz clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `update_i`  in  1  single-cycle scan request.
- `updating_o`  out  1  high while a scan is in progress.
- `done_o`  out  1  one-cycle pulse at scan end.
- `count_o`  out  ADDR_BITS+1  number of entries issued in the last completed scan.
- `bram_en_o`  out  1  BRAM access request.
- `bram_wr_o`  out  1  write qualifier, valid with `bram_en_o`.
- `bram_addr_o`  out  ADDR_BITS  access address.
- `bram_dat_o`  out  16  write data.
- `bram_gnt_i`  in  1  multiplexer grant. Monitor writes have priority over this port.
- `bram_dat_i`  in  16  read data, valid the cycle after a granted read (unregistered port).
- `cmd_valid_o`  out  1  command valid.
- `cmd_ready_i`  in  1  command engine ready.
- `cmd_addr_o`  out  ADDR_BITS  entry address.
- `cmd_dat_o`  out  15  entry value, bits 14:0.
- `force_all_i`  in  1  present only with `TOF_SCHED_FORCE_ALL_EN`.

## Operation
- States: IDLE, RD, RDW, ISSUE, VRD, VRW, WR, NEXT, DONE.
- **IDLE**
  - On `update_i` (or a pending rescan): pointer ← `FIRST_ADDR`, issued count ← 0, go to RD.
- **BRAM requests (RD, VRD, WR)**
  - Hold `bram_en_o`, address and data stable until `bram_gnt_i` is sampled high.
  - A granted RD goes to RDW.
- **RDW**
  - Latch the word as `orig`.
  - If bit 15 = 0, go to NEXT.
  - Otherwise go to ISSUE.
- **ISSUE**
  - `cmd_valid_o` = 1, `cmd_addr_o` = pointer, `cmd_dat_o` = `orig[14:0]`, all held until `cmd_ready_i`.
  - On the handshake: count +1, go to VRD.
- **VRD → VRW (re-read the same address)**
  - If the re-read equals `orig`, go to WR, which writes `{1'b0, orig[14:0]}`.
  - If it differs (a host write landed), skip the clear, set `rescan_pend`, go to NEXT.
- **NEXT**
  - If pointer = `LAST_ADDR`, go to DONE.
  - Otherwise pointer +1, go to RD.
- **DONE**
  - `done_o` = 1 and `count_o` ← count, for one cycle.
  - If `rescan_pend` is set: clear it and restart the scan from `FIRST_ADDR`.
  - Otherwise go to IDLE.
- **`update_i` during a scan**: sets `rescan_pend`. Multiple requests collapse into one rescan.
- **Residual race**: the host write and our WR can land in the same cycle. The BRAM port A write wins on the bit, and the host write still sets bit 15 on its next write. This residual window is accepted.
- **Reset** (any state, mid-handshake included):
  - Return to IDLE.
  - All outputs go to 0, including `count_o`; `rescan_pend` is cleared.
  - No BRAM write is issued after reset.

## Timing
- `updating_o` rises the cycle after `update_i` is sampled. It is low in IDLE and high in every other state, DONE included.
- With `bram_gnt_i` = 1 and `cmd_ready_i` = 1:
  - A clean entry costs 2 cycles (RD, RDW) plus NEXT: 3 cycles.
  - A dirty entry costs 7 cycles.
  - An all-clean scan of 128 entries is 384 cycles, plus 1 cycle for DONE.
- Each cycle `bram_gnt_i` = 0 adds one cycle to the affected access.
- Each cycle `cmd_ready_i` = 0 adds one cycle to ISSUE.
- `cmd_valid_o` never drops without a handshake, except on reset.

## Configuration
- **With `TOF_SCHED_FORCE_ALL_EN` defined**
  - Adds `force_all_i`, sampled with `update_i`.
  - If set, every entry is issued regardless of bit 15. A clean entry still runs VRD/VRW, but skips WR when bit 15 is already 0.
- **Without it**: port absent, and only dirty entries are issued.

## Structure
- **Package `tof_sched_pkg`**: state enum, `DIRTY_BIT` = 15, default `ADDR_BITS`.
- **Sub-module `tof_sched_bram_port`**: request/grant hold register and read-data capture, used by RD/VRD/WR.

## Test plan
- All-clean BRAM (128 entries, gnt/ready always 1), `update_i` → 0 commands, `done_o` at cycle 385, `count_o` = 0.
- Entries 3 and 100 = 0x8123 → commands (3, 0x0123) and (100, 0x0123) in that order. Both words read back as 0x0123. `count_o` = 2.
- Host rewrites addr 3 to 0x8055 between ISSUE and VRD → no clear. Automatic rescan issues (3, 0x0055), and addr 3 ends as 0x0055.
- `bram_gnt_i` low for 5 cycles during RD of addr 10; `cmd_ready_i` low for 4 cycles → address, data and valid held stable, no duplicate command.
- `update_i` pulsed 3× mid-scan → exactly one rescan, two `done_o` pulses total.
- `rst_i` asserted during ISSUE → all outputs 0 next cycle, no BRAM write, dirty bit left set. A following `update_i` reissues the entry.
